// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x3 key matrix scanner with integrated scan-rate divider,
// 2-flop row synchroniser, lowest-index priority and frame-based debounce.
// Optional 7-segment digit output enabled by defining KEYPAD_HEX_DISPLAY_EN.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] row,
   output logic [2:0] column,
   output logic [3:0] key,
   output logic       valid_key,
   output logic       key_down
`ifdef KEYPAD_HEX_DISPLAY_EN
   ,
   output logic [6:0] hex
`endif
);

   localparam int unsigned      CNT_W      = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [3:0]       KEY_NONE   = 4'hF;
   localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);

   logic [2:0]       row_meta;
   logic [2:0]       row_sync;
   logic [CNT_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic [1:0]       col_idx_next;
   logic             tick;
   logic             frame_end;
   logic [8:0]       frame;
   logic [8:0]       frame_next;
   logic [3:0]       cand;
   logic [3:0]       prev_cand;
   logic [3:0]       deb_cnt;
   logic             frame_done;
   logic [3:0]       stable;
   logic             accept;

   assign tick         = (div_cnt == CNT_LAST);
   assign frame_end    = tick && (col_idx == 2'd2);
   assign col_idx_next = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

   // Two-flop synchroniser on the asynchronous row lines (idle = pulled up)
   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   // Scan divider and active-low one-hot column drive
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         col_idx <= 2'd0;
         column  <= 3'b110;
      end else if (tick) begin
         div_cnt <= '0;
         col_idx <= col_idx_next;
         column  <= ~(3'b001 << col_idx_next);
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Merge the driven column's sample into the frame and pick the lowest pressed index
   always_comb begin
      frame_next = frame;
      if (tick) begin
         for (int unsigned r = 0; r < 3; r++) begin
            if (!row_sync[r]) frame_next[4'(r * 3) + 4'(col_idx)] = 1'b1;
         end
      end
      cand = KEY_NONE;
      for (int unsigned i = 0; i < 9; i++) begin
         if (frame_next[i] && (cand == KEY_NONE)) cand = 4'(i);
      end
   end

   // Frame accumulator, cleared once the last column has been folded in
   always_ff @(posedge clk) begin
      if (reset)          frame <= '0;
      else if (frame_end) frame <= '0;
      else                frame <= frame_next;
   end

   // Per-frame debounce: count consecutive identical candidates, saturating
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_cand  <= KEY_NONE;
         deb_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            prev_cand <= cand;
            if (cand == prev_cand)
               deb_cnt <= (deb_cnt >= DEB_TARGET) ? DEB_TARGET : deb_cnt + 4'd1;
            else
               deb_cnt <= 4'd1;
         end
      end
   end

   // Candidate is committed the cycle after its frame completes
   assign accept = frame_done && (deb_cnt == DEB_TARGET) && (prev_cand != stable);

   // Stable state and registered outputs; key holds its last value on release
   always_ff @(posedge clk) begin
      if (reset) begin
         stable    <= KEY_NONE;
         key       <= KEY_NONE;
         valid_key <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         key_down <= 1'b0;
         if (accept) begin
            stable <= prev_cand;
            if (prev_cand != KEY_NONE) begin
               key       <= prev_cand;
               valid_key <= 1'b1;
               key_down  <= 1'b1;
            end else begin
               valid_key <= 1'b0;
            end
         end
      end
   end

`ifdef KEYPAD_HEX_DISPLAY_EN
   // Active-low 7-segment digit of the held key, blank when no key is valid
   always_ff @(posedge clk) begin
      if (reset) begin
         hex <= '1;
      end else if (valid_key) begin
         case (key)
            4'd0:    hex <= 7'b1000000;
            4'd1:    hex <= 7'b1111001;
            4'd2:    hex <= 7'b0100100;
            4'd3:    hex <= 7'b0110000;
            4'd4:    hex <= 7'b0011001;
            4'd5:    hex <= 7'b0010010;
            4'd6:    hex <= 7'b0000010;
            4'd7:    hex <= 7'b1111000;
            4'd8:    hex <= 7'b0000000;
            default: hex <= '1;
         endcase
      end else begin
         hex <= '1;
      end
   end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_SCANS=2 (12-cycle frame). A behavioural key matrix drives row
// from the DUT column drive and the set of pressed keys.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [2:0] row;
   logic [2:0] column;
   logic [3:0] key;
   logic       valid_key;
   logic       key_down;
`ifdef KEYPAD_HEX_DISPLAY_EN
   logic [6:0] hex;
`endif

   logic [8:0] pressed;
   int         total;
   int         passed;
   int         failed;
   int         pulses;
   int         consec;
   logic       kd_prev;

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .row(row),
      .column(column),
      .key(key),
      .valid_key(valid_key),
      .key_down(key_down)
`ifdef KEYPAD_HEX_DISPLAY_EN
      ,
      .hex(hex)
`endif
   );

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key matrix: a pressed key pulls its row low only while its column is driven
   always_comb begin
      row = 3'b111;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (pressed[r*3+c] && !column[c]) row[r] = 1'b0;
         end
      end
   end

   // Count key_down pulses and back-to-back highs (pre-edge values)
   initial begin
      pulses  = 0;
      consec  = 0;
      kd_prev = 1'b0;
   end
   always @(posedge clk) begin
      if (key_down) pulses++;
      if (key_down && kd_prev) consec++;
      kd_prev = key_down;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_kd(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (key_down) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_released(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!valid_key) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic [2:0] pat [3];
      int         errs;
      int         snap;
      bit         seen;

      pat[0] = 3'b110;
      pat[1] = 3'b101;
      pat[2] = 3'b011;
      total   = 0;
      passed  = 0;
      failed  = 0;
      reset   = 1'b1;
      pressed = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_column", 32'(column), 32'h6);
      chk("rst_key", 32'(key), 32'hF);
      chk("rst_valid", 32'(valid_key), 32'h0);
      chk("rst_key_down", 32'(key_down), 32'h0);
`ifdef KEYPAD_HEX_DISPLAY_EN
      chk("rst_hex", 32'(hex), 32'h7F);
`endif

      // Idle: column walks 110,101,011 with 4 cycles each
      reset = 1'b0;
      errs  = 0;
      for (int k = 0; k < 24; k++) begin
         if (column !== pat[(k / 4) % 3]) errs++;
         @(negedge clk);
      end
      chk("idle_column_seq", 32'(errs), 32'h0);
      errs = 0;
      for (int k = 0; k < 76; k++) begin
         if (key !== 4'hF || valid_key !== 1'b0) errs++;
         @(negedge clk);
      end
      chk("idle_outputs", 32'(errs), 32'h0);
      chk("idle_pulses", 32'(pulses), 32'h0);

      // Hold key 5 (row1/col2)
      snap    = pulses;
      pressed = 9'b1 << 5;
      wait_kd(40, seen);
      chk("k5_key_down_seen", 32'(seen), 32'h1);
      chk("k5_key", 32'(key), 32'h5);
      chk("k5_valid", 32'(valid_key), 32'h1);
      repeat (200) @(negedge clk);
      chk("k5_single_pulse", 32'(pulses - snap), 32'h1);
      chk("k5_still_valid", 32'(valid_key), 32'h1);

      // Release key 5
      snap    = pulses;
      pressed = '0;
      wait_released(40, seen);
      chk("rel5_valid_low", 32'(seen), 32'h1);
      chk("rel5_key_holds", 32'(key), 32'h5);
      repeat (3) @(negedge clk);
      chk("rel5_no_pulse", 32'(pulses - snap), 32'h0);

      // One-frame glitch on key 0 must be rejected
      snap    = pulses;
      errs    = 0;
      pressed = 9'b1;
      repeat (12) @(negedge clk);
      pressed = '0;
      for (int k = 0; k < 40; k++) begin
         if (valid_key !== 1'b0) errs++;
         @(negedge clk);
      end
      chk("glitch_valid", 32'(errs), 32'h0);
      chk("glitch_key", 32'(key), 32'h5);
      chk("glitch_pulses", 32'(pulses - snap), 32'h0);

      // Keys 7 and 2 together: lowest index wins
      pressed = (9'b1 << 7) | (9'b1 << 2);
      wait_kd(40, seen);
      chk("k27_key_down_seen", 32'(seen), 32'h1);
      chk("k27_key", 32'(key), 32'h2);
      chk("k27_valid", 32'(valid_key), 32'h1);
      repeat (2) @(negedge clk);

      // Release 2, keep 7: change to 7 with one pulse, valid never drops
      snap    = pulses;
      errs    = 0;
      pressed = 9'b1 << 7;
      seen    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (valid_key !== 1'b1) errs++;
         if (key_down) begin
            seen = 1'b1;
            break;
         end
      end
      chk("k7_key_down_seen", 32'(seen), 32'h1);
      chk("k7_key", 32'(key), 32'h7);
      chk("k7_valid_held", 32'(errs), 32'h0);
      repeat (3) @(negedge clk);
      chk("k7_single_pulse", 32'(pulses - snap), 32'h1);

      // Release 7, then accept key 4
      pressed = '0;
      wait_released(40, seen);
      chk("rel7_valid_low", 32'(seen), 32'h1);
      pressed = 9'b1 << 4;
      wait_kd(40, seen);
      chk("k4_key_down_seen", 32'(seen), 32'h1);
      chk("k4_key", 32'(key), 32'h4);
      @(negedge clk);
`ifdef KEYPAD_HEX_DISPLAY_EN
      chk("k4_hex", 32'(hex), 32'h19);
`endif

      // One-cycle reset while key 4 is held
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_key", 32'(key), 32'hF);
      chk("mid_rst_valid", 32'(valid_key), 32'h0);
      chk("mid_rst_column", 32'(column), 32'h6);
      chk("mid_rst_key_down", 32'(key_down), 32'h0);
`ifdef KEYPAD_HEX_DISPLAY_EN
      chk("mid_rst_hex", 32'(hex), 32'h7F);
`endif
      wait_kd(40, seen);
      chk("k4_reacq_seen", 32'(seen), 32'h1);
      chk("k4_reacq_key", 32'(key), 32'h4);
      chk("k4_reacq_valid", 32'(valid_key), 32'h1);

      repeat (5) @(negedge clk);
      chk("no_back_to_back", 32'(consec), 32'h0);
      chk("total_pulses", 32'(pulses), 32'h5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
